// File: rtl/dm_responder_pkg.sv
// Shared CPU package for the data-memory responder.
// Provides the responder FSM state encoding, the access size codes,
// the default data-memory depth and the latched request record.
package dm_responder_pkg;

  localparam int DM_DEPTH_WORDS = 3072;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   size, is_unsigned, addr_lo : access shape (addr_lo = byte address [1:0])
//   wdata                      : right-aligned store data
//   rword                      : raw 32-bit word read from the array
//   be                         : byte enables for the store
//   wdata_rep                  : store data replicated into every lane
//   rdata                      : selected load lane(s), sign/zero-extended
// Illegal size yields no byte enables and zero read data.
module dm_lane_align
  import dm_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Shift the word down so the addressed lane lands in bits [7:0]/[15:0].
  always_comb begin
    rbyte = 8'(rword >> {addr_lo, 3'b000});
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    rdata     = '0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{~is_unsigned & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{~is_unsigned & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata     = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the Memory stage: accepts one load/store,
// waits WAIT_CYCLES, then presents a response held until consumed.
//   clk, reset          : clock, async active-low reset
//   req_*               : request handshake and fields (ready only in IDLE)
//   rsp_valid/ready     : response handshake
//   rsp_rdata, rsp_err  : extended load data (0 for stores/errors), error flag
//   busy                : state is not IDLE, used for pipeline stall
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dm_state_e     state, state_nxt;
  logic [3:0]    cnt;
  dm_req_t       req_q, cur;
  logic          accept, enter_resp, err, in_range;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep, rdata_ext, rword;

  logic [31:0]   mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // live request inputs must be used there instead of the latched copy.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur.we          = req_we;
      cur.addr        = req_addr;
      cur.size        = req_size;
      cur.is_unsigned = req_unsigned;
      cur.wdata       = req_wdata;
    end
  end

  assign in_range = {2'b00, cur.addr[31:2]} < 32'(DEPTH_WORDS);
  assign err      = (cur.size == 2'd3)
                  | ((cur.size == SZ_HALF) & cur.addr[0])
                  | ((cur.size == SZ_WORD) & (cur.addr[1:0] != 2'b00))
                  | ~in_range;
  assign idx      = cur.addr[AW+1:2];
  assign rword    = mem[idx];

  dm_lane_align u_align (
    .size        (cur.size),
    .is_unsigned (cur.is_unsigned),
    .addr_lo     (cur.addr[1:0]),
    .wdata       (cur.wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata       (rdata_ext)
  );

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nxt  = RESP;
        enter_resp = 1'b1;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q <= cur;
        cnt   <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_rdata <= (err || cur.we) ? 32'd0 : rdata_ext;
        rsp_err   <= err;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Array is not reset; the commit is gated by reset so a store pending in
  // WAIT is simply dropped when reset arrives.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && cur.we && !err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a request at the negedge of an IDLE cycle (accept cycle 0).
  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns the cycle index (accept cycle = 0) where rsp_valid is first seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat;
    drive_req(v.we, v.addr, v.size, v.uns, v.wdata);
    wait_rsp(lat);
    chk($sformatf("v%0d_latency", k), 32'(lat), 32'd3);
    chk($sformatf("v%0d_rdata", k), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", k), 32'(rsp_err), 32'(v.exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_idle_valid_err", k), {30'd0, rsp_valid, rsp_err}, 32'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;

    //           we    addr          size  uns   wdata          exp_rdata      err
    vecs.push_back('{1'b1, 32'h10,   2'd2, 1'b0, 32'h1234_5678, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{1'b1, 32'h13,   2'd0, 1'b0, 32'h0000_0080, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h13,   2'd0, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0});
    vecs.push_back('{1'b0, 32'h13,   2'd0, 1'b1, 32'h0,         32'h0000_0080, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,         32'h8034_5678, 1'b0});
    vecs.push_back('{1'b0, 32'h11,   2'd1, 1'b0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h12,   2'd2, 1'b0, 32'hCAFE_F00D, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,         32'h8034_5678, 1'b0});
    vecs.push_back('{1'b0, 32'h3000, 2'd2, 1'b0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h10,   2'd3, 1'b0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h12,   2'd1, 1'b0, 32'h0,         32'hFFFF_8034, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   2'd1, 1'b1, 32'h0,         32'h0000_5678, 1'b0});
    vecs.push_back('{1'b1, 32'h14,   2'd2, 1'b0, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h16,   2'd1, 1'b0, 32'h1234_ABCD, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h14,   2'd2, 1'b0, 32'h0,         32'hABCD_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h2FFC, 2'd2, 1'b0, 32'hA5A5_A5A5, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h2FFC, 2'd2, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b1, 32'h20,   2'd2, 1'b0, 32'h1111_2222, 32'h0,         1'b0});

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // Backpressure: response held, no second accept, no write to 0x10.
    drive_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'd3);
    req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid_busy_ready", c), {29'd0, rsp_valid, busy, req_ready}, 32'b110);
      chk($sformatf("bp%0d_rdata", c), rsp_rdata, 32'h8034_5678);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_after_busy", 32'(busy), 32'd0);
    run_vec(100, '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h8034_5678, 1'b0});

    // Reset while a store sits in WAIT.
    drive_req(1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF);
    chk("mid_wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid_err", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_vec(101, '{1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d expected finish", checks);
    $fatal(1);
  end

endmodule
